pmod_led_arbiter: RTL

- Shares the 8-LED Pmod bank between up to N_REQ pattern sources, e.g. the shift animation, a status display and a debug source.
- Round-robin arbitration with a minimum hold time, counted in prescaler ticks, before a pending requester can pre-empt the current owner.
- Applies per-requester PWM brightness to the granted pattern.
- Sits between the pattern generators and the p1..p10 LED pins; contains its own tick prescaler.

---
 rtl/pmod_led_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/pmod_led_arbiter.sv
`default_nettype none
// ==== pmod_led_arbiter: round-robin owner of the 8-LED Pmod bank with hold time and PWM (rev 1.0) ====
module pmod_led_arbiter #(
  parameter int N_REQ      = 4,
  parameter int TICK_DIV   = 8000000,
  parameter int HOLD_TICKS = 4,
  parameter int PWM_BITS   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [8*N_REQ-1:0]        pattern,
  input  logic [PWM_BITS*N_REQ-1:0] level,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic                      tick,
  output logic [7:0]                leds
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = $clog2(HOLD_TICKS + 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]       rr_q, rr_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PW-1:0]       presc_q;
  logic                tick_q;
  logic [PWM_BITS-1:0] pwm_q;
  logic [7:0]          leds_q, leds_d;

  logic                win_found;
  logic [IW-1:0]       win_idx;
  logic [IW:0]         scan_sum;
  logic [N_REQ-1:0]    win_onehot;
  logic [IW-1:0]       win_rr;
  logic                own_req;
  logic [7:0]          pat_g;
  logic [PWM_BITS-1:0] lvl_g;
  logic                pwm_on;

  // Scan from rr_q; the current owner is never its own successor.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(N_REQ)) scan_sum = scan_sum - (IW+1)'(N_REQ);
      if (!win_found && req[scan_sum[IW-1:0]] && !grant_q[scan_sum[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_sum[IW-1:0];
      end
    end
  end

  always_comb begin
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
    win_rr              = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
  end

  always_comb begin
    pat_g = '0;
    lvl_g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        pat_g = pattern[8*i +: 8];
        lvl_g = level[PWM_BITS*i +: PWM_BITS];
      end
    end
  end

  assign own_req = |(req & grant_q);
  assign pwm_on  = (lvl_g == {PWM_BITS{1'b1}}) || (pwm_q < lvl_g);
  assign leds_d  = ((state_q == ST_OWN) && pwm_on) ? pat_g : 8'h00;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_OWN;
          grant_d = win_onehot;
          rr_d    = win_rr;
          hold_d  = '0;
        end
      end
      ST_OWN: begin
        if ((!own_req || hold_q == HW'(HOLD_TICKS)) && win_found) begin
          grant_d = win_onehot;
          rr_d    = win_rr;
          hold_d  = '0;
        end else if (!own_req) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end else if (tick_q && hold_q != HW'(HOLD_TICKS)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      hold_q  <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      pwm_q   <= '0;
      leds_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      pwm_q   <= pwm_q + 1'b1;
      leds_q  <= leds_d;
      if (presc_q == PW'(TICK_DIV - 1)) begin
        presc_q <= '0;
        tick_q  <= 1'b1;
      end else begin
        presc_q <= presc_q + 1'b1;
        tick_q  <= 1'b0;
      end
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == ST_OWN);
  assign tick  = tick_q;
  assign leds  = leds_q;

endmodule
`default_nettype wire
